hazard_scoreboard: RTL

//  Parametrised successor of the combinational hazard unit. It tracks in-flight register writers in E/M/W
//  (3-slot shift register of dest/ready-stage tags), generates stall, PC/IFID enables and IDEX clear,
//  and produces forward selects for D-stage and E-stage operands.
//  It adds a multi-cycle HI/LO (mult/div) busy counter and flush handling.

---
 rtl/hazard_scoreboard_if.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: D-stage tags and E-stage sources in, stall/forward controls out.
// HZ_PERF_CNT_EN adds the perf_stall_cnt / perf_fwd_cnt observation counters.
interface hazard_scoreboard_if #(
  parameter int AW = 5
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [1:0]    id_rs_need;
  logic [1:0]    id_rt_need;
  logic [AW-1:0] id_dst;
  logic [1:0]    id_dst_rdy;
  logic          id_md_start;
  logic          id_hilo_use;
  logic          flush;
  logic [AW-1:0] e_rs;
  logic [AW-1:0] e_rt;

  logic          stall;
  logic          pc_en;
  logic          ifid_en;
  logic          idex_clr;
  logic [1:0]    fwd_d_rs;
  logic [1:0]    fwd_d_rt;
  logic [1:0]    fwd_e_rs;
  logic [1:0]    fwd_e_rt;
  logic          md_busy;
`ifdef HZ_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_fwd_cnt;
`endif

  modport master (
`ifdef HZ_PERF_CNT_EN
    input  perf_stall_cnt, perf_fwd_cnt,
`endif
    output id_valid, id_rs, id_rt, id_rs_need, id_rt_need, id_dst, id_dst_rdy,
    output id_md_start, id_hilo_use, flush, e_rs, e_rt,
    input  stall, pc_en, ifid_en, idex_clr,
    input  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );

  modport slave (
`ifdef HZ_PERF_CNT_EN
    output perf_stall_cnt, perf_fwd_cnt,
`endif
    input  id_valid, id_rs, id_rt, id_rs_need, id_rt_need, id_dst, id_dst_rdy,
    input  id_md_start, id_hilo_use, flush, e_rs, e_rt,
    output stall, pc_en, ifid_en, idex_clr,
    output fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: E/M/W writer tags, D/E forward selects, stall and mult/div busy window.
// Optional macro HZ_PERF_CNT_EN enables the stall and forward performance counters.
module hazard_scoreboard #(
  parameter int AW     = 5,
  parameter int MD_LAT = 8,
  parameter int CW     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   hz
);

  // Slot index 0 = E, 1 = M, 2 = W
  logic [2:0]          slotValid;
  logic [2:0][AW-1:0]  slotDst;
  logic [2:0][1:0]     slotRdy;
  logic [CW-1:0]       mdCnt;

  logic [2:0] rsRes;
  logic [2:0] rtRes;
  logic [1:0] eRsSel;
  logic [1:0] eRtSel;
  logic       mdBusy;
  logic       hiloStall;
  logic       stallInt;
  logic       accept;
  logic       mdAccept;

  function automatic logic [1:0] normCode(input logic [1:0] c);
    return (c == 2'b11) ? 2'b10 : c;
  endfunction

  // Returns {stall, fwd_sel}; only the youngest matching slot is considered.
  function automatic logic [2:0] dHazard(
    input logic [AW-1:0]     src,
    input logic [1:0]        needRaw,
    input logic [2:0]        sv,
    input logic [2:0][AW-1:0] sd,
    input logic [2:0][1:0]   sr
  );
    logic [1:0] need;
    logic       found;
    int         pos;
    logic       stl;
    logic [1:0] sel;
    need  = normCode(needRaw);
    found = 1'b0;
    pos   = 0;
    stl   = 1'b0;
    sel   = 2'b00;
    if ((need != 2'b00) && (src != '0)) begin
      for (int i = 0; i < 3; i++) begin
        if (!found && sv[i] && (sd[i] == src) && (sr[i] != 2'b00)) begin
          found = 1'b1;
          pos   = i;
        end
      end
      if (found) begin
        if ((pos + 1 + ((need == 2'b10) ? 1 : 0)) <= int'(sr[pos]))
          stl = 1'b1;
        if (need == 2'b01) begin
          if (pos == 1)      sel = 2'b01;
          else if (pos == 2) sel = 2'b10;
        end
      end
    end
    return {stl, sel};
  endfunction

  // M with a load result still pending yields no forward rather than falling through to W.
  function automatic logic [1:0] eForward(
    input logic [AW-1:0]     src,
    input logic [2:0]        sv,
    input logic [2:0][AW-1:0] sd,
    input logic [2:0][1:0]   sr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (sv[1] && (sd[1] == src) && (sr[1] != 2'b00))
        sel = (sr[1] == 2'b01) ? 2'b01 : 2'b00;
      else if (sv[2] && (sd[2] == src) && (sr[2] != 2'b00))
        sel = 2'b10;
    end
    return sel;
  endfunction

  assign rsRes  = dHazard(hz.id_rs, hz.id_rs_need, slotValid, slotDst, slotRdy);
  assign rtRes  = dHazard(hz.id_rt, hz.id_rt_need, slotValid, slotDst, slotRdy);
  assign eRsSel = eForward(hz.e_rs, slotValid, slotDst, slotRdy);
  assign eRtSel = eForward(hz.e_rt, slotValid, slotDst, slotRdy);

  assign mdBusy    = (mdCnt != '0);
  assign hiloStall = (hz.id_hilo_use | hz.id_md_start) & mdBusy;
  // reset low forces every control to its idle value
  assign stallInt  = reset & hz.id_valid & (rsRes[2] | rtRes[2] | hiloStall) & ~hz.flush;
  assign accept    = hz.id_valid & ~stallInt & ~hz.flush;
  assign mdAccept  = accept & hz.id_md_start;

  assign hz.stall    = stallInt;
  assign hz.pc_en    = ~stallInt;
  assign hz.ifid_en  = ~stallInt;
  assign hz.idex_clr = reset & (stallInt | hz.flush);
  assign hz.fwd_d_rs = reset ? rsRes[1:0] : 2'b00;
  assign hz.fwd_d_rt = reset ? rtRes[1:0] : 2'b00;
  assign hz.fwd_e_rs = reset ? eRsSel : 2'b00;
  assign hz.fwd_e_rt = reset ? eRtSel : 2'b00;
  assign hz.md_busy  = mdBusy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      slotValid <= '0;
      slotDst   <= '0;
      slotRdy   <= '0;
      mdCnt     <= '0;
    end else begin
      slotValid <= {slotValid[1:0], accept};
      slotDst   <= {slotDst[1:0], hz.id_dst};
      slotRdy   <= {slotRdy[1:0], normCode(hz.id_dst_rdy)};
      if (mdAccept)
        mdCnt <= CW'(MD_LAT);
      else if (mdBusy)
        mdCnt <= mdCnt - CW'(1);
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] fwdCnt;
  logic        anyFwd;

  assign anyFwd = (hz.fwd_d_rs != 2'b00) | (hz.fwd_d_rt != 2'b00) |
                  (hz.fwd_e_rs != 2'b00) | (hz.fwd_e_rt != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCnt <= '0;
      fwdCnt   <= '0;
    end else begin
      if (stallInt) stallCnt <= stallCnt + 32'd1;
      if (anyFwd)   fwdCnt   <= fwdCnt + 32'd1;
    end
  end

  assign hz.perf_stall_cnt = stallCnt;
  assign hz.perf_fwd_cnt   = fwdCnt;
`endif

endmodule
